lcd_read_fsm: RTL

- Read-side controller for the HD44780-style character LCD bus; the counterpart of the character-send FSM.
- Runs timed read cycles (RW=1) and samples the 8-bit data bus at the end of the enable pulse.
- Returns either one byte or the result of a busy-flag poll loop.
- Sits between the display sequencer and the LCD pins. Owns RS/RW/enable during a read and tells the top-level tristate to release the data bus.

---
 rtl/lcd_read_fsm.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/lcd_read_fsm.sv
// Read-side controller for an HD44780-style LCD bus: timed RW=1 cycles,
// single-byte reads or busy-flag polling with a bounded retry count.
module lcd_read_fsm #(
    parameter int SETUP_CYC   = 2,
    parameter int EN_HIGH_CYC = 6,
    parameter int EN_LOW_CYC  = 6,
    parameter int MAX_POLLS   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       readReq,
    input  logic       pollBusy,
    input  logic       RSin,
    input  logic [7:0] dataIn,
    output logic       RSout,
    output logic       RWout,
    output logic       enable,
    output logic       busOE,
    output logic [7:0] dataOut,
    output logic       readDone,
    output logic       timeout,
    output logic       busy
);
    // state   | meaning
    // IDLE    | bus driven by FPGA, waiting for readReq
    // SETUP   | RS/RW stable, enable low (address setup)
    // EN_HIGH | enable high, data sampled on the final edge
    // EN_LOW  | enable low, LCD still owns the bus
    // DONE    | one-cycle completion pulse

    localparam int MAX_SH = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
    localparam int MAX_C  = (MAX_SH > EN_LOW_CYC) ? MAX_SH : EN_LOW_CYC;
    localparam int CW     = $clog2(MAX_C + 1);
    localparam int PW     = $clog2(MAX_POLLS + 1);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HIGH_LD  = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] LOW_LD   = CW'(EN_LOW_CYC - 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(MAX_POLLS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_EN_HIGH = 3'd2,
        S_EN_LOW  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [PW-1:0] polls, polls_n;
    logic          rs_lat, rs_n;
    logic          poll_lat, poll_n;
    logic [7:0]    data_n;
    logic          to_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            polls    <= '0;
            rs_lat   <= 1'b0;
            poll_lat <= 1'b0;
            dataOut  <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            polls    <= polls_n;
            rs_lat   <= rs_n;
            poll_lat <= poll_n;
            dataOut  <= data_n;
            timeout  <= to_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        polls_n = polls;
        rs_n    = rs_lat;
        poll_n  = poll_lat;
        data_n  = dataOut;
        to_n    = timeout;
        case (state)
            S_IDLE: begin
                if (readReq) begin
                    // Polling always reads the status register, so RS is forced low.
                    rs_n    = RSin & ~pollBusy;
                    poll_n  = pollBusy;
                    to_n    = 1'b0;
                    polls_n = '0;
                    cnt_n   = SETUP_LD;
                    state_n = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    cnt_n   = HIGH_LD;
                    state_n = S_EN_HIGH;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_EN_HIGH: begin
                if (cnt == '0) begin
                    data_n  = dataIn;
                    polls_n = polls + PW'(1);
                    cnt_n   = LOW_LD;
                    state_n = S_EN_LOW;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_EN_LOW: begin
                if (cnt == '0) begin
                    if (poll_lat && dataOut[7] && (polls < POLL_MAX)) begin
                        cnt_n   = SETUP_LD;
                        state_n = S_SETUP;
                    end else begin
                        if (poll_lat && dataOut[7]) begin
                            to_n = 1'b1;
                        end
                        state_n = S_DONE;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign busy     = (state != S_IDLE);
    assign RWout    = busy;
    assign RSout    = busy & rs_lat;
    assign enable   = (state == S_EN_HIGH);
    assign busOE    = (state == S_IDLE);
    assign readDone = (state == S_DONE);

endmodule
